pend_enc_16_4: RTL and testbench
================================

# pend_enc_16_4

Registered 16-to-4 pending-event encoder: the reverse direction of the 4-to-16 decoder. It captures single-cycle event pulses on a 16-bit vector into sticky pending bits, and presents the highest-priority pending index as a 4-bit code with a valid/ready handshake. It clears each bit once its index is accepted. It sits between event sources and the consumer that drives the decoder, so a returned index `y` can be re-expanded to one-hot downstream.

## Interface
- `PRIO_HIGH`, default 1: 1 = bit 15 highest priority, bit 0 lowest; 0 = bit 0 highest, bit 15 lowest.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `en` in 1: capture enable; when 0, `d` is ignored and pending bits are still served.
- `d` in 16: event pulses; `d[i]`=1 sampled with `en`=1 sets pending bit i.
- `clr` in 1: synchronous flush of all pending bits, `valid` and `ovf`.
- `y` out 4: encoded index of the presented pending bit.
- `valid` out 1: `y` holds a pending index.
- `ready` in 1: consumer accepts `y`; handshake = `valid` & `ready` at a rising edge.
- `pend` out 16: current pending vector (status).
- `ovf` out 1: sticky; an event hit a bit that was already pending.

## Operation
- Reset (`rst_n`=0 at an edge): `pend`=16'h0000, `y`=4'h0, `valid`=0, `ovf`=0.
  - Reset overrides `clr`, `en`, `d` and `ready`.
- `clr`=1 (with `rst_n`=1): same values as reset on the next edge.
  - `clr` beats a simultaneous handshake and simultaneous events; the event is dropped.
- Accept mask `acc` = one-hot(`y`) when `valid` & `ready`, else 0.
- `set` = `en` ? `d` : 0.
- `pend_next` = (`pend` & ~`acc`) | `set`.
  - Set wins over clear on the same bit: the accepted bit is re-pended and served again later.
- `ovf` sets at an edge when (`set` & `pend` & ~`acc`) != 0.
  - `ovf` stays set until `clr` or reset.
  - The duplicate event is merged and produces one grant.
- Output state machine, two states:
  - IDLE: `valid`=0.
  - PRESENT: `valid`=1, `y` stable.
- Output register loads when `valid`=0 or `ready`=1:
  - `valid` <= |`pend_next`.
  - `y` <= priority encode of `pend_next` per `PRIO_HIGH`.
  - `y` <= 0 when `pend_next`=0.
- When `valid`=1 and `ready`=0, `y` and `valid` hold.
  - This holds even if a higher-priority event arrives; the new bit waits in `pend`.
- Transitions:
  - IDLE -> PRESENT when `pend_next`!=0.
  - PRESENT -> PRESENT on handshake with `pend_next`!=0; `y` takes the new index.
  - PRESENT -> IDLE on handshake with `pend_next`=0.
  - PRESENT holds without handshake.
  - Any state -> IDLE on `clr` or reset.
- The presented bit stays set in `pend` until accepted.
- `d`=0 with `en`=1 is a no-op.

## Timing
- All outputs are registered; there is no combinational path from `d`, `ready`, `en` or `clr` to any output.
- Latency: an event sampled at edge k into an idle block gives `valid`=1 with its index after edge k (one cycle).
- Throughput: one grant per cycle with `ready` held at 1; there are no bubbles between back-to-back grants.
- The next `y` appears after the same edge that accepts the previous one.
- Starvation of low-priority bits under continuous high-priority traffic is permitted (strict priority).
- Reset mid-operation: a pending grant is lost and no handshake completes on the reset edge.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `en`=1, `d`=16'hFFFF, `ready`=1 -> after release `valid`=0, `y`=0, `pend`=0, `ovf`=0.
- Single event: `d`=16'h0020 for one cycle, `ready`=1 -> next cycle `valid`=1, `y`=5; the cycle after, `valid`=0, `pend`=0.
- Priority order: `d`=16'h8101 for one cycle, `ready`=1.
  - `PRIO_HIGH`=1 -> `y` = 15, 8, 0 on three consecutive cycles, then `valid`=0.
  - `PRIO_HIGH`=0 -> `y` = 0, 8, 15.
- Hold/backpressure: `ready`=0, present `y`=3, then inject `d`=16'h8000 -> `y` stays 3 and `pend`=16'h8008. Raise `ready` -> `y`=15 next cycle (`PRIO_HIGH`=1), then `valid`=0.
- Overflow and set/clear collision:
  - With `ready`=0, `d`=16'h0004 on two separate cycles -> `ovf`=1, exactly one grant `y`=2.
  - Then, with `ready`=1 and `ovf` flushed, `d`=16'h0004 on the accept edge of `y`=2 -> a second grant `y`=2 next cycle, `ovf` stays 0.
- Flush mid-operation: `pend`=16'h00F0, `valid`=1, `clr`=1 with `ready`=1 and `d`=16'h0001 -> next cycle `valid`=0, `pend`=0, `ovf`=0, no further grants.

Source files
------------

// File: rtl/pend_enc_16_4_if.sv
// ---------------------------------------------------------------------------
// pend_enc_16_4_if
// Bus bundle between an event source / index consumer (master) and the
// pending-event encoder (slave).
//   en    : capture enable for d
//   d     : 16 single-cycle event pulses
//   clr   : synchronous flush of pending state
//   ready : consumer accepts y
//   y     : encoded index of the presented pending bit
//   valid : y holds a pending index
//   pend  : current pending vector (status)
//   ovf   : sticky, an event hit an already-pending bit
// ---------------------------------------------------------------------------
interface pend_enc_16_4_if;
    logic        en;
    logic [15:0] d;
    logic        clr;
    logic        ready;
    logic [3:0]  y;
    logic        valid;
    logic [15:0] pend;
    logic        ovf;

    modport master (
        output en, d, clr, ready,
        input  y, valid, pend, ovf
    );

    modport slave (
        input  en, d, clr, ready,
        output y, valid, pend, ovf
    );
endinterface

// File: rtl/pend_enc_16_4.sv
// ---------------------------------------------------------------------------
// pend_enc_16_4
// Registered 16-to-4 pending-event encoder. Event pulses on d are captured
// into sticky pending bits; the highest-priority pending index is presented
// on y with a valid/ready handshake and its bit is cleared once accepted.
//   PRIO_HIGH : 1 = bit 15 highest priority, 0 = bit 0 highest
//   clk       : single clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : slave side of pend_enc_16_4_if (en, d, clr, ready in;
//               y, valid, pend, ovf out, all registered)
// ---------------------------------------------------------------------------
module pend_enc_16_4 #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    pend_enc_16_4_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [15:0] pend_q, pend_next;
    logic [3:0]  y_q, y_next;
    logic        ovf_q, ovf_next;
    logic [15:0] acc, set;
    logic        load;

    // Priority encoder; later hits in the scan override earlier ones, so the
    // scan direction decides which end wins. Returns 0 for an empty vector.
    function automatic logic [3:0] prio_enc(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (PRIO_HIGH) begin
                if (v[i]) idx = 4'(i);
            end else begin
                if (v[15 - i]) idx = 4'(15 - i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        state_next = state;
        y_next     = y_q;

        acc  = (state == PRESENT && bus.ready) ? (16'd1 << y_q) : 16'h0000;
        set  = bus.en ? bus.d : 16'h0000;
        // Set wins over the accept-clear, so a re-fired accepted bit stays.
        pend_next = (pend_q & ~acc) | set;
        ovf_next  = ovf_q | (|(set & pend_q & ~acc));

        // The output register is frozen only while presenting without ready.
        load = (state == IDLE) || bus.ready;
        if (load) begin
            state_next = (|pend_next) ? PRESENT : IDLE;
            y_next     = prio_enc(pend_next);
        end

        if (bus.clr) begin
            state_next = IDLE;
            y_next     = 4'h0;
            pend_next  = 16'h0000;
            ovf_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            y_q    <= 4'h0;
            pend_q <= 16'h0000;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_next;
            y_q    <= y_next;
            pend_q <= pend_next;
            ovf_q  <= ovf_next;
        end
    end

    assign bus.valid = (state == PRESENT);
    assign bus.y     = y_q;
    assign bus.pend  = pend_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_pend_enc_16_4.sv
// ---------------------------------------------------------------------------
// tb_pend_enc_16_4
// Drives two encoders (PRIO_HIGH = 1 and 0) with identical stimulus and
// checks them against directed expectations and a behavioural model.
// ---------------------------------------------------------------------------
module tb_pend_enc_16_4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] d;
    logic        clr;
    logic        ready;

    int n_cmp;
    int n_bad;

    pend_enc_16_4_if ifa ();
    pend_enc_16_4_if ifb ();

    assign ifa.en = en;
    assign ifa.d = d;
    assign ifa.clr = clr;
    assign ifa.ready = ready;
    assign ifb.en = en;
    assign ifb.d = d;
    assign ifb.clr = clr;
    assign ifb.ready = ready;

    pend_enc_16_4 #(.PRIO_HIGH(1'b1)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pend_enc_16_4 #(.PRIO_HIGH(1'b0)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model; index 0 = bit 15 highest, index 1 = bit 0 highest.
    logic [15:0] mp [2];
    logic        mv [2];
    logic [3:0]  my [2];
    logic        mo [2];

    function automatic logic [3:0] top_idx(input logic [15:0] v, input bit high);
        if (high) begin
            for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
        end else begin
            for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        end
        return 4'h0;
    endfunction

    // One clock: advance the model from pre-edge inputs, then sample at negedge.
    task automatic step();
        logic [15:0] a, s, np;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) begin
                mp[k] = 16'h0; mv[k] = 1'b0; my[k] = 4'h0; mo[k] = 1'b0;
            end else begin
                a  = (mv[k] && ready) ? (16'd1 << my[k]) : 16'h0;
                s  = en ? d : 16'h0;
                if ((s & mp[k] & ~a) != 16'h0) mo[k] = 1'b1;
                np = (mp[k] & ~a) | s;
                if (!mv[k] || ready) begin
                    mv[k] = (np != 16'h0);
                    my[k] = top_idx(np, (k == 0));
                end
                mp[k] = np;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; d = 16'hFFFF; ready = 1'b1; clr = 1'b0;
        repeat (3) step();
        rst_n = 1'b1; en = 1'b0; d = 16'h0;
        step();
        n_cmp++;
        if (ifa.valid !== 1'b0 || ifa.y !== 4'h0 || ifa.pend !== 16'h0 || ifa.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hi: valid=%b y=%0d pend=%h ovf=%b, required 0/0/0000/0",
                     ifa.valid, ifa.y, ifa.pend, ifa.ovf);
        end
        n_cmp++;
        if (ifb.valid !== 1'b0 || ifb.y !== 4'h0 || ifb.pend !== 16'h0 || ifb.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_lo: valid=%b y=%0d pend=%h ovf=%b, required 0/0/0000/0",
                     ifb.valid, ifb.y, ifb.pend, ifb.ovf);
        end
    endtask

    task automatic test_single();
        en = 1'b1; ready = 1'b1; d = 16'h0020;
        step();
        d = 16'h0;
        n_cmp++;
        if (ifa.valid !== 1'b1 || ifa.y !== 4'd5) begin
            n_bad++;
            $display("FAIL single_grant: valid=%b y=%0d, required 1/5", ifa.valid, ifa.y);
        end
        step();
        n_cmp++;
        if (ifa.valid !== 1'b0 || ifa.pend !== 16'h0) begin
            n_bad++;
            $display("FAIL single_done: valid=%b pend=%h, required 0/0000", ifa.valid, ifa.pend);
        end
    endtask

    task automatic test_priority();
        logic [3:0] ea [3] = '{4'd15, 4'd8, 4'd0};
        logic [3:0] eb [3] = '{4'd0, 4'd8, 4'd15};
        en = 1'b1; ready = 1'b1; d = 16'h8101;
        step();
        d = 16'h0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ifa.valid !== 1'b1 || ifa.y !== ea[i]) begin
                n_bad++;
                $display("FAIL prio_hi[%0d]: valid=%b y=%0d, required 1/%0d", i, ifa.valid, ifa.y, ea[i]);
            end
            n_cmp++;
            if (ifb.valid !== 1'b1 || ifb.y !== eb[i]) begin
                n_bad++;
                $display("FAIL prio_lo[%0d]: valid=%b y=%0d, required 1/%0d", i, ifb.valid, ifb.y, eb[i]);
            end
            step();
        end
        n_cmp++;
        if (ifa.valid !== 1'b0 || ifb.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_end: valid_hi=%b valid_lo=%b, required 0/0", ifa.valid, ifb.valid);
        end
    endtask

    task automatic test_backpressure();
        en = 1'b1; ready = 1'b0; d = 16'h0008;
        step();
        d = 16'h8000;
        step();
        d = 16'h0;
        n_cmp++;
        if (ifa.valid !== 1'b1 || ifa.y !== 4'd3 || ifa.pend !== 16'h8008) begin
            n_bad++;
            $display("FAIL hold: valid=%b y=%0d pend=%h, required 1/3/8008", ifa.valid, ifa.y, ifa.pend);
        end
        step();
        n_cmp++;
        if (ifa.y !== 4'd3) begin
            n_bad++;
            $display("FAIL hold_again: y=%0d, required 3", ifa.y);
        end
        ready = 1'b1;
        step();
        n_cmp++;
        if (ifa.valid !== 1'b1 || ifa.y !== 4'd15 || ifa.pend !== 16'h8000) begin
            n_bad++;
            $display("FAIL release: valid=%b y=%0d pend=%h, required 1/15/8000", ifa.valid, ifa.y, ifa.pend);
        end
        step();
        n_cmp++;
        if (ifa.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_end: valid=%b, required 0", ifa.valid);
        end
    endtask

    task automatic test_overflow();
        en = 1'b1; ready = 1'b0; d = 16'h0004;
        step();
        d = 16'h0;
        step();
        d = 16'h0004;
        step();
        d = 16'h0;
        n_cmp++;
        if (ifa.ovf !== 1'b1 || ifa.valid !== 1'b1 || ifa.y !== 4'd2 || ifa.pend !== 16'h0004) begin
            n_bad++;
            $display("FAIL ovf_set: ovf=%b valid=%b y=%0d pend=%h, required 1/1/2/0004",
                     ifa.ovf, ifa.valid, ifa.y, ifa.pend);
        end
        ready = 1'b1;
        step();
        n_cmp++;
        if (ifa.valid !== 1'b0 || ifa.ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_one_grant: valid=%b ovf=%b, required 0/1", ifa.valid, ifa.ovf);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++;
        if (ifa.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_flush: ovf=%b, required 0", ifa.ovf);
        end
        d = 16'h0004;
        step();
        // d still 0004 on the edge that accepts y=2: the bit re-pends.
        step();
        d = 16'h0;
        n_cmp++;
        if (ifa.valid !== 1'b1 || ifa.y !== 4'd2 || ifa.ovf !== 1'b0 || ifa.pend !== 16'h0004) begin
            n_bad++;
            $display("FAIL collide: valid=%b y=%0d ovf=%b pend=%h, required 1/2/0/0004",
                     ifa.valid, ifa.y, ifa.ovf, ifa.pend);
        end
        step();
        n_cmp++;
        if (ifa.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_end: valid=%b, required 0", ifa.valid);
        end
    endtask

    task automatic test_flush();
        en = 1'b1; ready = 1'b0; d = 16'h00F0;
        step();
        clr = 1'b1; ready = 1'b1; d = 16'h0001;
        step();
        clr = 1'b0; d = 16'h0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ifa.valid !== 1'b0 || ifa.pend !== 16'h0 || ifa.ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL flush[%0d]: valid=%b pend=%h ovf=%b, required 0/0000/0",
                         i, ifa.valid, ifa.pend, ifa.ovf);
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            en    = ($urandom_range(0, 3) != 0);
            d     = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            ready = ($urandom_range(0, 2) != 0);
            step();
            n_cmp++;
            if (ifa.valid !== mv[0] || ifa.y !== my[0] || ifa.pend !== mp[0] || ifa.ovf !== mo[0]) begin
                n_bad++;
                $display("FAIL rand_hi c=%0d: valid=%b y=%0d pend=%h ovf=%b, required %b/%0d/%h/%b",
                         c, ifa.valid, ifa.y, ifa.pend, ifa.ovf, mv[0], my[0], mp[0], mo[0]);
            end
            n_cmp++;
            if (ifb.valid !== mv[1] || ifb.y !== my[1] || ifb.pend !== mp[1] || ifb.ovf !== mo[1]) begin
                n_bad++;
                $display("FAIL rand_lo c=%0d: valid=%b y=%0d pend=%h ovf=%b, required %b/%0d/%h/%b",
                         c, ifb.valid, ifb.y, ifb.pend, ifb.ovf, mv[1], my[1], mp[1], mo[1]);
            end
        end
        rst_n = 1'b1; clr = 1'b0; en = 1'b0; d = 16'h0; ready = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < 2; k++) begin
            mp[k] = 16'h0; mv[k] = 1'b0; my[k] = 4'h0; mo[k] = 1'b0;
        end
        rst_n = 1'b0; en = 1'b0; d = 16'h0; clr = 1'b0; ready = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_overflow();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
